// File: rtl/testic_monitor_if.sv
// Bus between the TestIC receive-side monitor and its environment.
// DUTY_MEAS_EN adds the high_time/low_time results.
interface testic_monitor_if #(
    parameter int CNT_W = 16
);
    logic             Q;
    logic             not_Q;
    logic             clear;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic [CNT_W-1:0] edge_count;
    logic             locked;
    logic             complement_err;
    logic             timeout_err;
    logic [1:0]       state;
`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;

    modport master (
        output Q, not_Q, clear,
        input  half_period, period_valid, edge_count, locked,
               complement_err, timeout_err, state, high_time, low_time
    );
    modport slave (
        input  Q, not_Q, clear,
        output half_period, period_valid, edge_count, locked,
               complement_err, timeout_err, state, high_time, low_time
    );
`else
    modport master (
        output Q, not_Q, clear,
        input  half_period, period_valid, edge_count, locked,
               complement_err, timeout_err, state
    );
    modport slave (
        input  Q, not_Q, clear,
        output half_period, period_valid, edge_count, locked,
               complement_err, timeout_err, state
    );
`endif
endinterface

// File: rtl/testic_monitor.sv
// Receive-side checker for the TestIC Q/not_Q pair: half-period measurement,
// lock detection, complement and timeout faults. DUTY_MEAS_EN adds high/low time capture.
module testic_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_EDGES  = 4,
    parameter int TOL         = 1,
    parameter int SKEW_CYC    = 2
) (
    input logic CLK,
    input logic not_RESET,
    testic_monitor_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2, LOST = 2'd3;
    localparam int MC_W = $clog2(LOCK_EDGES + 1);
    localparam int SK_W = $clog2(SKEW_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(LOCK_EDGES - 1);
    localparam logic [SK_W-1:0]  SKEW_MAX = SK_W'(SKEW_CYC);

    logic [SYNC_STAGES-1:0] q_sync, nq_sync;
    logic                   q_d;
    logic                   q_s, nq_s, edge_det, match;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt, half_period, edge_count;
    logic             period_valid, timeout_err, complement_err;
    logic [MC_W-1:0]  match_cnt;
    logic [SK_W-1:0]  skew_cnt;
`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] high_time, low_time;
`endif

    // not_Q chain idles high so a reset pair already looks complementary.
    always_ff @(posedge CLK or negedge not_RESET) begin
        if (!not_RESET) begin
            q_sync  <= '0;
            nq_sync <= '1;
            q_d     <= 1'b0;
        end else begin
            q_sync  <= {q_sync[SYNC_STAGES-2:0], bus.Q};
            nq_sync <= {nq_sync[SYNC_STAGES-2:0], bus.not_Q};
            q_d     <= q_sync[SYNC_STAGES-1];
        end
    end

    assign q_s      = q_sync[SYNC_STAGES-1];
    assign nq_s     = nq_sync[SYNC_STAGES-1];
    assign edge_det = q_s ^ q_d;
    assign match    = period_valid &&
                      ({1'b0, cnt} <= {1'b0, half_period} + TOL_X) &&
                      ({1'b0, half_period} <= {1'b0, cnt} + TOL_X);

    always_ff @(posedge CLK or negedge not_RESET) begin
        if (!not_RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            edge_count   <= '0;
            match_cnt    <= '0;
            timeout_err  <= 1'b0;
`ifdef DUTY_MEAS_EN
            high_time    <= '0;
            low_time     <= '0;
`endif
        end else if (bus.clear) begin
            state        <= IDLE;
            cnt          <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            edge_count   <= '0;
            match_cnt    <= '0;
            timeout_err  <= 1'b0;
`ifdef DUTY_MEAS_EN
            high_time    <= '0;
            low_time     <= '0;
`endif
        end else begin
            if (edge_det && edge_count != CNT_MAX)
                edge_count <= edge_count + 1'b1;
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state <= ACQUIRE;
                        cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (edge_det) begin
                        cnt          <= {{(CNT_W-1){1'b0}}, 1'b1};
                        half_period  <= cnt;
                        period_valid <= 1'b1;
`ifdef DUTY_MEAS_EN
                        // q_s already shows the new level: high now means the low phase just ended.
                        if (q_s) low_time  <= cnt;
                        else     high_time <= cnt;
`endif
                        if (!match) begin
                            match_cnt <= '0;
                            state     <= ACQUIRE;
                        end else if (state == ACQUIRE) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MC_LAST) state <= LOCKED;
                        end
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        if (cnt >= CNT_MAX - 1'b1) begin
                            state       <= LOST;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Interval that ends a timeout is meaningless, so it is not captured.
                    if (edge_det) begin
                        state     <= ACQUIRE;
                        match_cnt <= '0;
                        cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // A single cycle of equality is normal synchronizer skew between the two lines.
    always_ff @(posedge CLK or negedge not_RESET) begin
        if (!not_RESET) begin
            skew_cnt       <= '0;
            complement_err <= 1'b0;
        end else if (bus.clear) begin
            skew_cnt       <= '0;
            complement_err <= 1'b0;
        end else if (q_s == nq_s) begin
            if (skew_cnt != SKEW_MAX) skew_cnt <= skew_cnt + 1'b1;
            if (skew_cnt == SKEW_MAX - 1'b1) complement_err <= 1'b1;
        end else begin
            skew_cnt <= '0;
        end
    end

    assign bus.half_period    = half_period;
    assign bus.period_valid   = period_valid;
    assign bus.edge_count     = edge_count;
    assign bus.locked         = (state == LOCKED);
    assign bus.complement_err = complement_err;
    assign bus.timeout_err    = timeout_err;
    assign bus.state          = state;
`ifdef DUTY_MEAS_EN
    assign bus.high_time      = high_time;
    assign bus.low_time       = low_time;
`endif
endmodule
